// File: rtl/mrnaiso_pkg.sv
// Shared types and constants for the mRNA-isolation valve sequencer.
package mrnaiso_pkg;

    // Phase codes double as the externally visible phase output.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CELLS   = 3'd1,
        S_BEADS   = 3'd2,
        S_LYSIS   = 3'd3,
        S_MIX     = 3'd4,
        S_SEP     = 3'd5,
        S_COLLECT = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    // One bit per valve line; 1 = actuated (closed).
    typedef logic [9:0] valve_t;

    localparam int V_COLLECT   = 0;
    localparam int V_LYSIS_IN  = 1;
    localparam int V_LYSIS_OUT = 2;
    localparam int V_PUSH      = 3;
    localparam int V_SEP       = 4;
    localparam int V_SIEVE     = 5;
    localparam int V_WASTE     = 6;
    localparam int V_BEADS     = 7;
    localparam int V_CELLS_IN  = 8;
    localparam int V_CELLS_OUT = 9;

    // Peristaltic pattern as {pump1,pump2,pump3}.
    localparam logic [2:0] PUMP_PAT [0:5] = '{3'b011, 3'b001, 3'b101, 3'b100, 3'b110, 3'b010};

    // A zero dwell would never expire; clamp to one cycle.
    function automatic int eff_dwell(input int t);
        return (t < 1) ? 1 : t;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Valves that are open (driven 0) in each state.
    function automatic valve_t open_mask(input state_t s);
        valve_t m;
        m = '0;
        case (s)
            S_CELLS:   begin m[V_CELLS_IN] = 1'b1; m[V_CELLS_OUT] = 1'b1; m[V_SIEVE] = 1'b1; end
            S_BEADS:   begin m[V_BEADS] = 1'b1; m[V_WASTE] = 1'b1; m[V_SIEVE] = 1'b1; end
            S_LYSIS:   begin m[V_LYSIS_IN] = 1'b1; m[V_LYSIS_OUT] = 1'b1; end
            S_SEP:     begin m[V_SEP] = 1'b1; m[V_SIEVE] = 1'b1; m[V_WASTE] = 1'b1; m[V_PUSH] = 1'b1; end
            S_COLLECT: begin m[V_COLLECT] = 1'b1; m[V_SEP] = 1'b1; m[V_PUSH] = 1'b1; end
            default:   m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mrnaiso_peristaltic_pump.sv
// Peristaltic pump stepper: walks the 6-step pattern while enabled.
module mrnaiso_peristaltic_pump
    import mrnaiso_pkg::*;
#(
    parameter int PUMP_STEP = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,      // pump is in use on the cycle after this edge
    input  logic hold,
    input  logic clear,
    output logic pump1,
    output logic pump2,
    output logic pump3,
    output logic round_wrap   // this edge moves step 5 back to step 0
);
    localparam int PS = eff_dwell(PUMP_STEP);
    localparam int SW = (PS > 1) ? $clog2(PS) : 1;

    logic [SW-1:0] step_cnt;
    logic [2:0]    idx;
    logic [2:0]    idx_next;
    logic [2:0]    pumps;
    logic          running;
    logic          step_end;

    assign step_end   = (step_cnt == SW'(PS - 1));
    assign idx_next   = (idx == 3'd5) ? 3'd0 : idx + 3'd1;
    assign round_wrap = running && !hold && !clear && step_end && (idx == 3'd5);
    assign {pump1, pump2, pump3} = pumps;

    // Step counter, pattern index and registered pump lines.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            step_cnt <= '0;
            idx      <= '0;
            pumps    <= 3'b111;
            running  <= 1'b0;
        end else if (!hold) begin
            if (!enable) begin
                step_cnt <= '0;
                idx      <= '0;
                pumps    <= 3'b111;
                running  <= 1'b0;
            end else if (!running) begin
                step_cnt <= '0;
                idx      <= '0;
                pumps    <= PUMP_PAT[0];
                running  <= 1'b1;
            end else if (step_end) begin
                step_cnt <= '0;
                idx      <= idx_next;
                pumps    <= PUMP_PAT[idx_next];
            end else begin
                step_cnt <= step_cnt + SW'(1);
            end
        end
    end

endmodule

// File: rtl/mrnaiso_valve_sequencer.sv
// Isolation-cycle sequencer: start pulse to timed valve/pump actuation.
module mrnaiso_valve_sequencer
    import mrnaiso_pkg::*;
#(
    parameter int T_CELLS    = 20,
    parameter int T_BEADS    = 20,
    parameter int T_LYSIS    = 30,
    parameter int PUMP_STEP  = 4,
    parameter int MIX_ROUNDS = 8,
    parameter int T_SEP      = 25,
    parameter int T_COLLECT  = 15,
    parameter int CW         = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       hold,
    output logic       busy,
    output logic       done,
    output logic       aborted,
    output logic [2:0] phase,
    output logic       collect_ctrl,
    output logic       lysis_in_ctrl,
    output logic       lysis_out_ctrl,
    output logic       push_ctrl,
    output logic       sep_ctrl,
    output logic       sieve_ctrl,
    output logic       waste_ctrl,
    output logic       beads_ctrl,
    output logic       cells_in_ctrl,
    output logic       cells_out_ctrl,
    output logic       pump1,
    output logic       pump2,
    output logic       pump3
);
    localparam int TC      = eff_dwell(T_CELLS);
    localparam int TB      = eff_dwell(T_BEADS);
    localparam int TL      = eff_dwell(T_LYSIS);
    localparam int TS      = eff_dwell(T_SEP);
    localparam int TO      = eff_dwell(T_COLLECT);
    localparam int MR      = eff_dwell(MIX_ROUNDS);
    localparam int MIX_LEN = 6 * eff_dwell(PUMP_STEP) * MR;
    localparam int MAX_DUR = max_int(max_int(max_int(TC, TB), max_int(TL, TS)), max_int(TO, MIX_LEN));

    generate
        if ((64'd1 << CW) <= 64'(MAX_DUR)) begin : g_cw_check
            $error("CW too narrow for the longest phase");
        end
    endgenerate

    state_t        state, state_n, nxt;
    logic [CW-1:0] cnt, cnt_n, last;
    logic          done_n, aborted_n, tick, round_wrap;
    valve_t        valves;

    mrnaiso_peristaltic_pump #(.PUMP_STEP(PUMP_STEP)) u_pump (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (state_n == S_MIX),
        .hold       (hold),
        .clear      (abort),
        .pump1      (pump1),
        .pump2      (pump2),
        .pump3      (pump3),
        .round_wrap (round_wrap)
    );

    // In MIX the counter counts pump rounds instead of cycles.
    assign tick = (state == S_MIX) ? round_wrap : 1'b1;

    // Next state, counter and pulse outputs; abort beats hold beats start.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        done_n    = 1'b0;
        aborted_n = 1'b0;
        last      = '0;
        nxt       = state;
        case (state)
            S_CELLS:   begin last = CW'(TC - 1); nxt = S_BEADS;   end
            S_BEADS:   begin last = CW'(TB - 1); nxt = S_LYSIS;   end
            S_LYSIS:   begin last = CW'(TL - 1); nxt = S_MIX;     end
            S_MIX:     begin last = CW'(MR - 1); nxt = S_SEP;     end
            S_SEP:     begin last = CW'(TS - 1); nxt = S_COLLECT; end
            S_COLLECT: begin last = CW'(TO - 1); nxt = S_DONE;    end
            default:   begin last = '0;          nxt = state;     end
        endcase
        if (abort) begin
            if (state != S_IDLE) begin
                state_n   = S_IDLE;
                cnt_n     = '0;
                aborted_n = 1'b1;
            end
        end else if (!hold) begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state_n = S_CELLS;
                        cnt_n   = '0;
                    end
                end
                S_DONE: state_n = S_IDLE;
                default: begin
                    if (tick) begin
                        if (cnt == last) begin
                            state_n = nxt;
                            cnt_n   = '0;
                            done_n  = (nxt == S_DONE);
                        end else begin
                            cnt_n = cnt + CW'(1);
                        end
                    end
                end
            endcase
        end
    end

    // State register and registered control outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            aborted <= 1'b0;
            valves  <= '1;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            busy    <= (state_n != S_IDLE);
            done    <= done_n;
            aborted <= aborted_n;
            valves  <= ~open_mask(state_n);
        end
    end

    assign phase          = state;
    assign collect_ctrl   = valves[V_COLLECT];
    assign lysis_in_ctrl  = valves[V_LYSIS_IN];
    assign lysis_out_ctrl = valves[V_LYSIS_OUT];
    assign push_ctrl      = valves[V_PUSH];
    assign sep_ctrl       = valves[V_SEP];
    assign sieve_ctrl     = valves[V_SIEVE];
    assign waste_ctrl     = valves[V_WASTE];
    assign beads_ctrl     = valves[V_BEADS];
    assign cells_in_ctrl  = valves[V_CELLS_IN];
    assign cells_out_ctrl = valves[V_CELLS_OUT];

endmodule
